key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 101 ++++++++++
 tb/tb_key_debounce.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: four independent debounced channels with one-cycle rise/fall
// pulses. Each channel runs a two-flop synchronizer, then a run-length counter.
// The counter must see the synchronized input disagree with the debounced
// level for DEBOUNCE_CYCLES consecutive cycles before the level follows it.
// Optional build macro KEY_DEBOUNCE_TOGGLE_EN: adds a per-channel toggle flop
// that flips once per rising press. Without the macro, toggle is tied to 0.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          differ, settle;

  assign differ = (sync2 != level);
  assign settle = differ && (cnt == LAST);

  // two-flop synchronizer for the raw asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // run-length counter: any agreement (bounce back) restarts it, and it clears
  // on the settling edge, so it never goes past LAST and never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (!differ || settle) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

  // debounced level and its edge pulses, all registered on the settling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= settle &&  sync2;
      fall <= settle && !sync2;
      if (settle) level <= sync2;
    end
  end

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  // toggle flips on the edge following each rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    toggle <= 1'b0;
    else if (rise) toggle <= ~toggle;
  end
`else
  assign toggle = 1'b0;
`endif

endmodule

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [3:0] level,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic [3:0] toggle
);
  localparam int NUM_LANES = 4;

  // one fully independent debounce lane per channel
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in[g]),
      .level  (level[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .toggle (toggle[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES = 4. The reference model applies
// the sliding-window rule directly: a channel's level flips on edge t when the
// input sampled on edges t-D-1 .. t-2 all disagree with the current level.
module tb_key_debounce;
  localparam int D = 4;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in = 4'b0;
  logic [3:0] level, rise, fall, toggle;

  int total = 0;
  int bad   = 0;

  key_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .toggle (toggle)
  );

  always #5 clk = ~clk;

  // reference model: history of sampled inputs, hist[0] = most recent edge
  logic [3:0] hist [0:D];
  logic [3:0] m_level = 4'b0, m_rise = 4'b0, m_fall = 4'b0, m_tog = 4'b0;
  bit         all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D; k++) hist[k] = 4'b0;
      m_level = 4'b0; m_rise = 4'b0; m_fall = 4'b0; m_tog = 4'b0;
    end else begin
      if (TOG) m_tog = m_tog ^ m_rise;
      for (int ch = 0; ch < 4; ch++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (hist[k][ch] == m_level[ch]) all_diff = 1'b0;
        m_rise[ch] = all_diff && !m_level[ch];
        m_fall[ch] = all_diff &&  m_level[ch];
        if (all_diff) m_level[ch] = ~m_level[ch];
      end
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in;
    end
  end

  wire [15:0] obs = {level, rise, fall, toggle};
  wire [15:0] mdl = {m_level, m_rise, m_fall, m_tog};

  // stimulus helper: clean reset, ending just after a falling edge
  task automatic do_reset();
    @(negedge clk);
    in = 4'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in = 4'b1011;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 16'h0) begin
      bad++; $display("FAIL reset_async: got %h expected 0000", obs);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (obs !== 16'h0) begin
        bad++; $display("FAIL reset_hold: got %h expected 0000", obs);
      end
    end
    in = 4'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int rises = 0;
    do_reset();
    in = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (level !== ((k >= D + 2) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL latency_level edge %0d: got %b expected %b", k, level, (k >= D + 2) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (fall !== 4'b0 || obs !== mdl) begin
        bad++; $display("FAIL latency_model edge %0d: got %h expected %h", k, obs, mdl);
      end
      if (rise == 4'b0001) rises++;
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL latency_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      in = (k < 20) ? {2'b00, 1'(k / 2 % 2), 1'b0} : 4'b0;
      @(negedge clk);
      total++;
      if (level !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || obs !== mdl) begin
        bad++; $display("FAIL glitch cycle %0d: got %h expected %h", k, obs, mdl);
      end
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      in = (ph == 0) ? 4'hF : 4'h0;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        total++;
        if (((ph == 0) ? rise : fall) !== ((k == D + 2) ? 4'hF : 4'h0) || obs !== mdl) begin
          bad++; $display("FAIL all_channels ph %0d edge %0d: got %h expected %h", ph, k, obs, mdl);
        end
      end
      total++;
      if (level !== ((ph == 0) ? 4'hF : 4'h0)) begin
        bad++; $display("FAIL all_channels_level ph %0d: got %b", ph, level);
      end
    end
  endtask

  task automatic test_reset_midcount();
    int rises = 0;
    do_reset();
    in = 4'b0100;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 16'h0) begin
      bad++; $display("FAIL midreset_async: got %h expected 0000", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (level[2] !== (k >= D + 2) || obs !== mdl) begin
        bad++; $display("FAIL midreset edge %0d: got %h expected %h", k, obs, mdl);
      end
      if (rise[2]) rises++;
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL midreset_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 20; k++) begin
        in = (k < 10) ? 4'b1000 : 4'b0000;
        @(negedge clk);
        total++;
        if (obs !== mdl) begin
          bad++; $display("FAIL toggle_model press %0d cycle %0d: got %h expected %h", p, k, obs, mdl);
        end
      end
      total++;
      if (toggle !== (TOG ? {~p[0], 3'b000} : 4'b0000)) begin
        bad++; $display("FAIL toggle press %0d: got %b expected %b", p, toggle, TOG ? {~p[0], 3'b000} : 4'b0000);
      end
    end
  endtask

  task automatic test_near_miss();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      in = (k == 4) ? 4'b0 : 4'b0001;
      @(negedge clk);
      total++;
      if (level[0] !== (k >= 10) || obs !== mdl) begin
        bad++; $display("FAIL near_miss edge %0d: got %h expected %h", k, obs, mdl);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] flip;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++)
        flip[b] = ($urandom_range(0, 99) < ((k < 300) ? 12 : 30));
      in = in ^ flip;
      @(negedge clk);
      total++;
      if (obs !== mdl || (rise & fall) !== 4'b0) begin
        bad++; $display("FAIL random cycle %0d: got %h expected %h", k, obs, mdl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_all_channels();
    test_reset_midcount();
    test_toggle();
    test_near_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
